// File: rtl/mfe_pkg.sv
// rtl/mfe_pkg.sv - shared types and constants for the median-filter image memory arbiter
package mfe_pkg;

   localparam int AW_DEF = 14;
   localparam int DW_DEF = 8;
   localparam int IMG_W  = 128;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_OWN_A = 2'd1,
      S_OWN_B = 2'd2
   } state_t;

   typedef enum logic {
      TAG_A = 1'b0,
      TAG_B = 1'b1
   } tag_t;

endpackage

// File: rtl/mfe_mem_arbiter_if.sv
// rtl/mfe_mem_arbiter_if.sv - requester A/B and image memory signals of the arbiter
interface mfe_mem_arbiter_if import mfe_pkg::*; #(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
);

   logic          req_a;
   logic [AW-1:0] addr_a;
   logic          gnt_a;
   logic          rvalid_a;
   logic [DW-1:0] rdata_a;

   logic          req_b;
   logic          we_b;
   logic [AW-1:0] addr_b;
   logic [DW-1:0] wdata_b;
   logic          gnt_b;
   logic          rvalid_b;
   logic [DW-1:0] rdata_b;

   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_wen;
   logic          mem_ren;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  req_a, addr_a, req_b, we_b, addr_b, wdata_b, mem_rdata,
      output gnt_a, rvalid_a, rdata_a, gnt_b, rvalid_b, rdata_b,
             mem_addr, mem_wdata, mem_wen, mem_ren
   );

   modport master (
      output req_a, addr_a, req_b, we_b, addr_b, wdata_b, mem_rdata,
      input  gnt_a, rvalid_a, rdata_a, gnt_b, rvalid_b, rdata_b,
             mem_addr, mem_wdata, mem_wen, mem_ren
   );

endinterface

// File: rtl/mfe_rd_return.sv
// rtl/mfe_rd_return.sv - two-stage owner tag pipeline steering memory read data back to A or B
module mfe_rd_return import mfe_pkg::*; #(
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_rd_accept,
   input  tag_t          i_tag,
   input  logic [DW-1:0] i_mem_rdata,
   output logic          o_rvalid_a,
   output logic [DW-1:0] o_rdata_a,
   output logic          o_rvalid_b,
   output logic [DW-1:0] o_rdata_b
);

   logic r_v1;
   logic r_v2;
   tag_t r_tag1;
   tag_t r_tag2;

   // Stage 1 lines up with mem_ren, stage 2 with mem_rdata.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_v1   <= 1'b0;
         r_v2   <= 1'b0;
         r_tag1 <= TAG_A;
         r_tag2 <= TAG_A;
      end else begin
         r_v1   <= i_rd_accept;
         r_tag1 <= i_tag;
         r_v2   <= r_v1;
         r_tag2 <= r_tag1;
      end
   end

   assign o_rvalid_a = r_v2 && (r_tag2 == TAG_A);
   assign o_rvalid_b = r_v2 && (r_tag2 == TAG_B);
   assign o_rdata_a  = o_rvalid_a ? i_mem_rdata : '0;
   assign o_rdata_b  = o_rvalid_b ? i_mem_rdata : '0;

endmodule

// File: rtl/mfe_mem_arbiter.sv
// rtl/mfe_mem_arbiter.sv - round-robin bounded-burst arbiter between filter engine and host on the image memory
module mfe_mem_arbiter import mfe_pkg::*; #(
   parameter int MAX_BURST = 9,
   parameter int AW        = AW_DEF,
   parameter int DW        = DW_DEF
) (
   input  logic             clk,
   input  logic             reset,
   mfe_mem_arbiter_if.slave bus
);

   localparam int            CW         = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

   state_t        r_state;
   logic [CW-1:0] r_burst_cnt;
   tag_t          r_rr_last;
   logic [AW-1:0] r_mem_addr;
   logic [DW-1:0] r_mem_wdata;
   logic          r_mem_wen;
   logic          r_mem_ren;

   logic          w_gnt_a;
   logic          w_gnt_b;
   logic          w_burst_end;
   logic          w_rd_accept;
   tag_t          w_tag;
   logic          w_rvalid_a;
   logic          w_rvalid_b;
   logic [DW-1:0] w_rdata_a;
   logic [DW-1:0] w_rdata_b;

   assign w_gnt_a     = (r_state == S_OWN_A) && bus.req_a;
   assign w_gnt_b     = (r_state == S_OWN_B) && bus.req_b;
   assign w_burst_end = (r_burst_cnt == BURST_LAST);
   assign w_rd_accept = w_gnt_a || (w_gnt_b && !bus.we_b);
   assign w_tag       = w_gnt_b ? TAG_B : TAG_A;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_burst_cnt <= '0;
         r_rr_last   <= TAG_B;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_burst_cnt <= '0;
               if (bus.req_a && bus.req_b)
                  r_state <= (r_rr_last == TAG_A) ? S_OWN_B : S_OWN_A;
               else if (bus.req_a)
                  r_state <= S_OWN_A;
               else if (bus.req_b)
                  r_state <= S_OWN_B;
            end
            S_OWN_A: begin
               if (!bus.req_a || (w_burst_end && bus.req_b)) begin
                  r_state     <= bus.req_b ? S_OWN_B : S_IDLE;
                  r_burst_cnt <= '0;
                  r_rr_last   <= TAG_A;
               end else if (!w_burst_end) begin
                  r_burst_cnt <= r_burst_cnt + 1'b1;
               end
            end
            S_OWN_B: begin
               if (!bus.req_b || (w_burst_end && bus.req_a)) begin
                  r_state     <= bus.req_a ? S_OWN_A : S_IDLE;
                  r_burst_cnt <= '0;
                  r_rr_last   <= TAG_B;
               end else if (!w_burst_end) begin
                  r_burst_cnt <= r_burst_cnt + 1'b1;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_burst_cnt <= '0;
            end
         endcase
      end
   end

   // Strobes are single-cycle; address and data hold between commands.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_wen   <= 1'b0;
         r_mem_ren   <= 1'b0;
      end else begin
         r_mem_wen <= w_gnt_b && bus.we_b;
         r_mem_ren <= w_rd_accept;
         if (w_gnt_a || w_gnt_b)
            r_mem_addr <= w_gnt_a ? bus.addr_a : bus.addr_b;
         if (w_gnt_b)
            r_mem_wdata <= bus.wdata_b;
      end
   end

   mfe_rd_return #(.DW(DW)) u_rd_return (
      .clk         (clk),
      .reset       (reset),
      .i_rd_accept (w_rd_accept),
      .i_tag       (w_tag),
      .i_mem_rdata (bus.mem_rdata),
      .o_rvalid_a  (w_rvalid_a),
      .o_rdata_a   (w_rdata_a),
      .o_rvalid_b  (w_rvalid_b),
      .o_rdata_b   (w_rdata_b)
   );

   assign bus.gnt_a     = w_gnt_a;
   assign bus.gnt_b     = w_gnt_b;
   assign bus.rvalid_a  = w_rvalid_a;
   assign bus.rdata_a   = w_rdata_a;
   assign bus.rvalid_b  = w_rvalid_b;
   assign bus.rdata_b   = w_rdata_b;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.mem_wen   = r_mem_wen;
   assign bus.mem_ren   = r_mem_ren;

endmodule
